// File: rtl/psram_arbiter.sv
// Two-requester front end for the dual-channel ip_psram controller: maps linear byte
// addresses onto the two chips and arbitrates per channel. Define PSRAM_ARB_RR_EN for round-robin contention.
module psram_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int PSRAM_AW = 24
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                a_rd,
  input  logic                a_wr,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [7:0]          a_wdata,
  output logic                a_busy,
  output logic [7:0]          a_rdata,
  output logic                a_rdata_en,
  input  logic                b_rd,
  input  logic                b_wr,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [7:0]          b_wdata,
  output logic                b_busy,
  output logic [7:0]          b_rdata,
  output logic                b_rdata_en,
  output logic                rd0,
  output logic                wr0,
  output logic [PSRAM_AW-1:0] address0,
  output logic [7:0]          wdata0,
  input  logic                busy0,
  input  logic [7:0]          rdata0,
  input  logic                rdata0_en,
  output logic                rd1,
  output logic                wr1,
  output logic [PSRAM_AW-1:0] address1,
  output logic [7:0]          wdata1,
  input  logic                busy1,
  input  logic [7:0]          rdata1,
  input  logic                rdata1_en
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]        req_rd, req_wr, req_done;
  logic [ADDR_W-1:0] req_addr [2];
  logic [7:0]        req_wdata [2];
  logic [1:0]        pend_valid, pend_wr;
  logic [ADDR_W-1:0] pend_addr [2];
  logic [7:0]        pend_wdata [2];

  // Per-channel views of the ip_psram ports.
  logic [1:0]          ch_busy, ch_rdata_en, ch_rd, ch_wr;
  logic [7:0]          ch_rdata [2];
  logic [PSRAM_AW-1:0] ch_addr [2];
  logic [7:0]          ch_wdata [2];
  logic [7:0]          ch_cap [2];
  logic [1:0]          done_a, done_b, rden_a, rden_b;

  assign req_rd       = {b_rd, a_rd};
  assign req_wr       = {b_wr, a_wr};
  assign req_addr[0]  = a_address;
  assign req_addr[1]  = b_address;
  assign req_wdata[0] = a_wdata;
  assign req_wdata[1] = b_wdata;
  assign req_done     = {|done_b, |done_a};

  assign ch_busy      = {busy1, busy0};
  assign ch_rdata_en  = {rdata1_en, rdata0_en};
  assign ch_rdata[0]  = rdata0;
  assign ch_rdata[1]  = rdata1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic              valid_reg, wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;

    // A pulse is only accepted while the slot is empty; rd wins over wr.
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        valid_reg <= 1'b0;
        wr_reg    <= 1'b0;
        addr_reg  <= '0;
        wdata_reg <= '0;
      end else if (!valid_reg && (req_rd[gi] || req_wr[gi])) begin
        valid_reg <= 1'b1;
        wr_reg    <= !req_rd[gi];
        addr_reg  <= req_addr[gi];
        wdata_reg <= req_wdata[gi];
      end else if (req_done[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign pend_valid[gi] = valid_reg;
    assign pend_wr[gi]    = wr_reg;
    assign pend_addr[gi]  = addr_reg;
    assign pend_wdata[gi] = wdata_reg;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              op_wr_reg, op_wr_next;
    logic              first_reg, first_next;
    logic [ADDR_W-2:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next, rdata_reg, rdata_next;
    logic              want_a, want_b, grant_b;

    assign want_a = pend_valid[0] && (pend_addr[0][ADDR_W-1] == 1'(gi));
    assign want_b = pend_valid[1] && (pend_addr[1][ADDR_W-1] == 1'(gi));

`ifdef PSRAM_ARB_RR_EN
    // last_reg: 1 = B won the most recent contention; resets to B so A goes first.
    logic last_reg, last_next;
    assign grant_b = want_b && (!want_a || !last_reg);

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) last_reg <= 1'b1;
      else          last_reg <= last_next;
    end
`else
    assign grant_b = want_b && !want_a;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        state_reg <= IDLE;
        owner_reg <= 1'b0;
        op_wr_reg <= 1'b0;
        first_reg <= 1'b0;
        addr_reg  <= '0;
        wdata_reg <= '0;
        rdata_reg <= '0;
      end else begin
        state_reg <= state_next;
        owner_reg <= owner_next;
        op_wr_reg <= op_wr_next;
        first_reg <= first_next;
        addr_reg  <= addr_next;
        wdata_reg <= wdata_next;
        rdata_reg <= rdata_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      op_wr_next = op_wr_reg;
      first_next = 1'b0;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
`ifdef PSRAM_ARB_RR_EN
      last_next  = last_reg;
`endif
      case (state_reg)
        IDLE: begin
          if ((want_a || want_b) && !ch_busy[gi]) begin
            owner_next = grant_b;
            op_wr_next = pend_wr[grant_b];
            addr_next  = pend_addr[grant_b][ADDR_W-2:0];
            wdata_next = pend_wdata[grant_b];
            state_next = ISSUE;
`ifdef PSRAM_ARB_RR_EN
            if (want_a && want_b) last_next = grant_b;
`endif
          end
        end
        ISSUE: begin
          first_next = 1'b1;
          state_next = WAIT;
        end
        WAIT: begin
          // Writes ignore busy for the first WAIT cycle so the controller can raise it.
          if (op_wr_reg) begin
            if (!first_reg && !ch_busy[gi]) state_next = DONE;
          end else if (ch_rdata_en[gi]) begin
            rdata_next = ch_rdata[gi];
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    assign ch_rd[gi]    = (state_reg == ISSUE) && !op_wr_reg;
    assign ch_wr[gi]    = (state_reg == ISSUE) && op_wr_reg;
    assign ch_addr[gi]  = {{(PSRAM_AW-ADDR_W+1){1'b0}}, addr_reg};
    assign ch_wdata[gi] = wdata_reg;
    assign ch_cap[gi]   = rdata_reg;
    assign done_a[gi]   = (state_reg == DONE) && !owner_reg;
    assign done_b[gi]   = (state_reg == DONE) && owner_reg;
    assign rden_a[gi]   = done_a[gi] && !op_wr_reg;
    assign rden_b[gi]   = done_b[gi] && !op_wr_reg;
  end

  assign a_busy     = pend_valid[0];
  assign b_busy     = pend_valid[1];
  assign a_rdata_en = |rden_a;
  assign b_rdata_en = |rden_b;
  assign a_rdata    = (rden_a[0] ? ch_cap[0] : 8'h00) | (rden_a[1] ? ch_cap[1] : 8'h00);
  assign b_rdata    = (rden_b[0] ? ch_cap[0] : 8'h00) | (rden_b[1] ? ch_cap[1] : 8'h00);

  assign rd0      = ch_rd[0];
  assign wr0      = ch_wr[0];
  assign address0 = ch_addr[0];
  assign wdata0   = ch_wdata[0];
  assign rd1      = ch_rd[1];
  assign wr1      = ch_wr[1];
  assign address1 = ch_addr[1];
  assign wdata1   = ch_wdata[1];

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the dual-channel ip_psram controller between two byte-wide requesters.
- Requester A is the MSX bus slot logic. Requester B is the SD loader or test sequencer.
- Maps each requester's 23-bit linear byte address onto one of the two 4 MB PSRAM chips, sequences the rd/wr pulses into ip_psram, and routes read data back to the requester that owns the access.
- Sits between bus/loader logic and ip_psram in tangcart_msx; both clocked by the 54 MHz clk.

Parameters:
- ADDR_W, 23, requester address width; bit ADDR_W-1 selects the chip (0 = channel 0, 1 = channel 1).
- PSRAM_AW, 24, width of ip_psram address0/address1; upper bits above ADDR_W-2 are driven 0.

Ports:
- clk  in  1  system clock, 54 MHz; all logic on posedge.
- n_reset  in  1  asynchronous active-low reset.
- a_rd  in  1  requester A read request, one-cycle pulse.
- a_wr  in  1  requester A write request, one-cycle pulse.
- a_address  in  23  requester A byte address, sampled with the pulse.
- a_wdata  in  8  requester A write data, sampled with the pulse.
- a_busy  out  1  A request pending or in flight.
- a_rdata  out  8  A read data.
- a_rdata_en  out  1  one-cycle strobe, a_rdata valid.
- b_rd, b_wr, b_address, b_wdata, b_busy, b_rdata, b_rdata_en  same as A, for requester B.
- rd0, wr0  out  1  pulses to ip_psram channel 0.
- address0  out  24  channel 0 address.
- wdata0  out  8  channel 0 write data.
- busy0  in  1  channel 0 busy.
- rdata0  in  8  channel 0 read data.
- rdata0_en  in  1  channel 0 read data valid.
- rd1, wr1, address1, wdata1, busy1, rdata1, rdata1_en  same as channel 0, for channel 1.

Behaviour:
- Reset: every output is 0, all pending and owner registers are cleared, and both channel FSMs go to IDLE. Reset mid-access abandons the access; no rdata_en follows.

Request capture:
- On a rd or wr pulse with the requester's busy low, latch op, address and wdata into a pending slot. busy goes high on the next cycle.
- Requester contract: after a pulse, wait one cycle before sampling busy.
- A pulse while busy is high is ignored.
- rd and wr asserted together: treat as a read.
- Each requester has at most one outstanding access.

Channel FSM, one per channel, states IDLE, ISSUE, WAIT, DONE:
- IDLE: if a pending slot targets this channel and ip busyN is 0, select an owner and go to ISSUE.
- ISSUE: drive rdN or wrN for exactly one cycle. addressN = {0, addr[21:0]}; wdataN = the latched data. Go to WAIT.
- WAIT, write: wait at least one cycle, then until busyN = 0, then go to DONE.
- WAIT, read: wait for rdataN_en. Capture rdataN and go to DONE.
- DONE: clear the owner's pending slot and owner busy. For a read, pulse owner rdata_en for one cycle with the captured data. Return to IDLE.
- Read latency to the requester: ip rdataN_en plus 1 cycle.

Arbitration:
- Decision is made in IDLE only.
- A and B targeting different channels run fully in parallel.
- Both targeting the same channel: A wins (fixed priority) unless PSRAM_ARB_RR_EN is defined. The loser stays pending and issues after the winner's DONE.
- addressN and wdataN hold their values from ISSUE until the next ISSUE.
- Simultaneous a_rdata_en and b_rdata_en from different channels is legal.

Optional Feature:
- PSRAM_ARB_RR_EN defined: each channel keeps a last-owner bit. On same-channel contention the requester that did not win last goes first. The bit resets to B, so A wins the first contention.
- PSRAM_ARB_RR_EN undefined: fixed priority, A always wins. Under continuous A traffic B may starve.

Test Plan:
1. A writes 0x5A to addr 0x000123, then reads it back → wr0 pulse with address0 = 0x000123 and wdata0 = 0x5A; the read returns a_rdata = 0x5A with one a_rdata_en; channel 1 stays idle.
2. B writes 0xC3 to addr 0x400010 → wr1 pulse with address1 = 0x000010; channel 0 untouched; b_busy clears after busy1 falls.
3. A reads 0x000000 and B reads 0x400000 in the same cycle → rd0 and rd1 issue in the same cycle; both rdata_en strobes arrive; no blocking between requesters.
4. A and B both write to channel 0 in the same cycle → macro off: A issues first, then B. Macro on, two contentions in a row: first A then B, second B then A.
5. a_wr pulsed again while a_busy = 1 → the second request is ignored; exactly one wr0 pulse.
6. n_reset asserted during WAIT of a read → all outputs 0; no a_rdata_en after release; a new request after reset completes normally.
